seg7_pair_reader: RTL and testbench

- Receive-side counterpart of the two-digit seconds display driver. Samples the 7-bit ten and one segment buses and accepts a pair only once it has been stable.
- Decodes an accepted pair back to BCD and binary, flags blank and illegal patterns, and checks that successive values follow the seconds-counter sequence.
- Used as a display-path monitor and as a loopback checker in the lab3 bench and on-board self-test.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_digit_decode.sv | 28 ++
 rtl/seg7_pair_reader.sv | 157 +++++++++++++++
 tb/tb_seg7_pair_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment pair reader.
// Segment patterns are active-low with bit6=g down to bit0=a.
package seg7_pkg;

   localparam logic [6:0] SEG_D0    = 7'b1000000;
   localparam logic [6:0] SEG_D1    = 7'b1111001;
   localparam logic [6:0] SEG_D2    = 7'b0100100;
   localparam logic [6:0] SEG_D3    = 7'b0110000;
   localparam logic [6:0] SEG_D4    = 7'b0011001;
   localparam logic [6:0] SEG_D5    = 7'b0010010;
   localparam logic [6:0] SEG_D6    = 7'b0000010;
   localparam logic [6:0] SEG_D7    = 7'b1011000;
   localparam logic [6:0] SEG_D8    = 7'b0000000;
   localparam logic [6:0] SEG_D9    = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIG_BLANK     = 4'hF;
   localparam logic [3:0] DIG_ILLEGAL   = 4'hE;
   localparam logic [6:0] VALUE_INVALID = 7'd127;

   typedef enum logic {
      WAIT_FIRST,
      LOCKED
   } state_t;

   // Binary value of a decoded pair, VALUE_INVALID unless both digits are 0-9.
   function automatic logic [6:0] pair_value(input logic [3:0] ten, input logic [3:0] one);
      logic [6:0] v;
      if (ten <= 4'd9 && one <= 4'd9) begin
         v = ({3'b000, ten} * 7'd10) + {3'b000, one};
      end else begin
         v = VALUE_INVALID;
      end
      return v;
   endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational seven-segment pattern to digit code decoder.
// Unknown patterns map to DIG_ILLEGAL, all-off maps to DIG_BLANK.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] code_o
);

   always_comb begin
      code_o = DIG_ILLEGAL;
      case (seg_i)
         SEG_D0:    code_o = 4'd0;
         SEG_D1:    code_o = 4'd1;
         SEG_D2:    code_o = 4'd2;
         SEG_D3:    code_o = 4'd3;
         SEG_D4:    code_o = 4'd4;
         SEG_D5:    code_o = 4'd5;
         SEG_D6:    code_o = 4'd6;
         SEG_D7:    code_o = 4'd7;
         SEG_D8:    code_o = 4'd8;
         SEG_D9:    code_o = 4'd9;
         SEG_BLANK: code_o = DIG_BLANK;
         default:   code_o = DIG_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/seg7_pair_reader.sv
// Receive-side monitor for a two-digit seconds display: debounces the segment
// pair, decodes it and checks that accepted values follow the seconds count.
//
// state      | meaning
// WAIT_FIRST | nothing accepted since reset; next acceptance is unchecked
// LOCKED     | at least one pair accepted; sequence check active
module seg7_pair_reader
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [6:0]  i_ten,
   input  logic [6:0]  i_one,
   input  logic        i_clear,
   output logic        o_valid,
   output logic [3:0]  o_ten_bcd,
   output logic [3:0]  o_one_bcd,
   output logic [6:0]  o_value,
   output logic        o_blank,
   output logic        o_illegal,
   output logic        o_seq_err,
   output logic [15:0] o_count
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   state_t      state_q, state_d;
   logic [13:0] cand_q, cand_d;
   logic [7:0]  stab_q, stab_d;
   logic [13:0] last_q, last_d;
   logic        valid_q, valid_d;
   logic [3:0]  ten_bcd_q, ten_bcd_d;
   logic [3:0]  one_bcd_q, one_bcd_d;
   logic [6:0]  value_q, value_d;
   logic        blank_q, blank_d;
   logic        illegal_q, illegal_d;
   logic        seq_err_q, seq_err_d;
   logic [15:0] count_q, count_d;

   logic [13:0] pair_in;
   logic        differ;
   logic        reach;
   logic        accept;
   logic        violation;
   logic [3:0]  ten_code;
   logic [3:0]  one_code;
   logic [6:0]  new_value;
   logic [6:0]  expect_value;
   logic [15:0] count_base;

   seg7_digit_decode u_dec_ten (
      .seg_i  (i_ten),
      .code_o (ten_code)
   );

   seg7_digit_decode u_dec_one (
      .seg_i  (i_one),
      .code_o (one_code)
   );

   assign pair_in   = {i_ten, i_one};
   assign differ    = (pair_in != cand_q);
   assign new_value = pair_value(ten_code, one_code);

   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      stab_d       = stab_q;
      last_d       = last_q;
      valid_d      = 1'b0;
      ten_bcd_d    = ten_bcd_q;
      one_bcd_d    = one_bcd_q;
      value_d      = value_q;
      blank_d      = blank_q;
      illegal_d    = illegal_q;
      seq_err_d    = i_clear ? 1'b0 : seq_err_q;
      count_base   = i_clear ? 16'd0 : count_q;
      count_d      = count_base;
      expect_value = (value_q == 7'd99) ? 7'd0 : value_q + 7'd1;

      if (differ) begin
         cand_d = pair_in;
         stab_d = 8'd1;
      end else if (stab_q != STABLE_MAX) begin
         stab_d = stab_q + 8'd1;
      end

      // Acceptance only on the edge the count arrives at the threshold, so a
      // saturated hold never re-fires.
      reach  = (stab_d == STABLE_MAX) && (differ || stab_q != STABLE_MAX);
      accept = reach && ((state_q == WAIT_FIRST) || (pair_in != last_q));

      violation = accept && (state_q == LOCKED)
                  && (value_q != VALUE_INVALID) && (new_value != VALUE_INVALID)
                  && (new_value != 7'd0) && (new_value != expect_value);

      if (accept) begin
         state_d   = LOCKED;
         last_d    = pair_in;
         valid_d   = 1'b1;
         ten_bcd_d = ten_code;
         one_bcd_d = one_code;
         value_d   = new_value;
         blank_d   = (ten_code == DIG_BLANK) || (one_code == DIG_BLANK);
         illegal_d = (ten_code == DIG_ILLEGAL) || (one_code == DIG_ILLEGAL);
         if (count_base != 16'hFFFF) begin
            count_d = count_base + 16'd1;
         end
      end

      if (violation) begin
         seq_err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= WAIT_FIRST;
         cand_q    <= {SEG_BLANK, SEG_BLANK};
         stab_q    <= 8'd0;
         last_q    <= {SEG_BLANK, SEG_BLANK};
         valid_q   <= 1'b0;
         ten_bcd_q <= DIG_BLANK;
         one_bcd_q <= DIG_BLANK;
         value_q   <= VALUE_INVALID;
         blank_q   <= 1'b0;
         illegal_q <= 1'b0;
         seq_err_q <= 1'b0;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         stab_q    <= stab_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
         ten_bcd_q <= ten_bcd_d;
         one_bcd_q <= one_bcd_d;
         value_q   <= value_d;
         blank_q   <= blank_d;
         illegal_q <= illegal_d;
         seq_err_q <= seq_err_d;
         count_q   <= count_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_ten_bcd = ten_bcd_q;
   assign o_one_bcd = one_bcd_q;
   assign o_value   = value_q;
   assign o_blank   = blank_q;
   assign o_illegal = illegal_q;
   assign o_seq_err = seq_err_q;
   assign o_count   = count_q;

endmodule

// File: tb/tb_seg7_pair_reader.sv
// Directed bench for seg7_pair_reader with STABLE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_pair_reader;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [6:0]  i_ten;
   logic [6:0]  i_one;
   logic        i_clear;
   logic        o_valid;
   logic [3:0]  o_ten_bcd;
   logic [3:0]  o_one_bcd;
   logic [6:0]  o_value;
   logic        o_blank;
   logic        o_illegal;
   logic        o_seq_err;
   logic [15:0] o_count;

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

   seg7_pair_reader #(.STABLE_CYCLES(4)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_ten     (i_ten),
      .i_one     (i_one),
      .i_clear   (i_clear),
      .o_valid   (o_valid),
      .o_ten_bcd (o_ten_bcd),
      .o_one_bcd (o_one_bcd),
      .o_value   (o_value),
      .o_blank   (o_blank),
      .o_illegal (o_illegal),
      .o_seq_err (o_seq_err),
      .o_count   (o_count)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_valid) pulses <= pulses + 1;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic apply_raw(input logic [6:0] t, input logic [6:0] o, input int n);
      @(negedge i_clk);
      i_ten = t;
      i_one = o;
      repeat (n) @(posedge i_clk);
   endtask

   task automatic apply(input int t, input int o, input int n);
      apply_raw(seg_tab[t], seg_tab[o], n);
   endtask

   task automatic settle();
      repeat (2) @(negedge i_clk);
   endtask

   task automatic pulse_clear();
      @(negedge i_clk);
      i_clear = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_clear = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_ten   = 7'h7F;
      i_one   = 7'h7F;
      i_clear = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_value", o_value, 127);
      check_eq("rst_ten_bcd", o_ten_bcd, 15);
      check_eq("rst_count", o_count, 0);

      // 23 held: pulse after the 4th edge only
      i_rst_n = 1'b1;
      i_ten = seg_tab[2];
      i_one = seg_tab[3];
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_eq("t1_early_valid", o_valid, 0);
      @(posedge i_clk);
      @(negedge i_clk);
      check_eq("t1_valid", o_valid, 1);
      check_eq("t1_ten_bcd", o_ten_bcd, 2);
      check_eq("t1_one_bcd", o_one_bcd, 3);
      check_eq("t1_value", o_value, 23);
      check_eq("t1_count", o_count, 1);
      check_eq("t1_seq_err", o_seq_err, 0);
      @(negedge i_clk);
      check_eq("t1_no_repulse", o_valid, 0);

      // short glitch to 24 then back to 23
      apply(2, 4, 2);
      apply(2, 3, 6);
      settle();
      check_eq("t2_pulses", pulses, 1);
      check_eq("t2_count", o_count, 1);
      check_eq("t2_value", o_value, 23);

      // 23 -> 98 is a sequence jump
      apply(9, 8, 10);
      settle();
      check_eq("t3_98_value", o_value, 98);
      check_eq("t3_98_seq_err", o_seq_err, 1);
      check_eq("t3_98_count", o_count, 2);
      pulse_clear();
      check_eq("t3_clr_seq_err", o_seq_err, 0);
      check_eq("t3_clr_count", o_count, 0);
      apply(9, 9, 10);
      settle();
      check_eq("t3_99_value", o_value, 99);
      apply(0, 0, 10);
      settle();
      check_eq("t3_00_value", o_value, 0);
      check_eq("t3_00_seq_err", o_seq_err, 0);
      check_eq("t3_00_count", o_count, 2);
      apply(0, 5, 10);
      settle();
      check_eq("t3_05_value", o_value, 5);
      check_eq("t3_05_seq_err", o_seq_err, 1);
      check_eq("t3_pulses", pulses, 5);

      // illegal one digit
      apply_raw(seg_tab[1], 7'b1111110, 4);
      settle();
      check_eq("t4_illegal", o_illegal, 1);
      check_eq("t4_blank", o_blank, 0);
      check_eq("t4_ten_bcd", o_ten_bcd, 1);
      check_eq("t4_one_bcd", o_one_bcd, 14);
      check_eq("t4_value", o_value, 127);
      check_eq("t4_seq_err", o_seq_err, 1);
      check_eq("t4_count", o_count, 4);
      pulse_clear();
      check_eq("t4_clr_seq_err", o_seq_err, 0);
      check_eq("t4_clr_count", o_count, 0);

      // blank ten digit, then 01 and 02
      apply_raw(7'h7F, seg_tab[0], 4);
      settle();
      check_eq("t5_blank", o_blank, 1);
      check_eq("t5_illegal", o_illegal, 0);
      check_eq("t5_ten_bcd", o_ten_bcd, 15);
      check_eq("t5_one_bcd", o_one_bcd, 0);
      check_eq("t5_value", o_value, 127);
      apply(0, 1, 4);
      settle();
      check_eq("t5_01_value", o_value, 1);
      check_eq("t5_01_seq_err", o_seq_err, 0);
      check_eq("t5_01_blank", o_blank, 0);
      apply(0, 2, 4);
      settle();
      check_eq("t5_02_seq_err", o_seq_err, 0);
      check_eq("t5_02_count", o_count, 3);
      apply_raw(7'h7F, 7'b1111110, 4);
      settle();
      check_eq("t5_both_blank", o_blank, 1);
      check_eq("t5_both_illegal", o_illegal, 1);

      // clear coinciding with an acceptance edge
      apply(0, 3, 3);
      @(negedge i_clk);
      i_clear = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_clear = 1'b0;
      check_eq("t5_clr_acc_valid", o_valid, 1);
      check_eq("t5_clr_acc_count", o_count, 1);
      check_eq("t5_clr_acc_value", o_value, 3);

      // reset during stabilization of 45
      apply(4, 5, 2);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check_eq("t6_rst_count", o_count, 0);
      check_eq("t6_rst_value", o_value, 127);
      check_eq("t6_rst_one_bcd", o_one_bcd, 15);
      check_eq("t6_rst_blank", o_blank, 0);
      check_eq("t6_rst_illegal", o_illegal, 0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_eq("t6_early_valid", o_valid, 0);
      @(posedge i_clk);
      @(negedge i_clk);
      check_eq("t6_valid", o_valid, 1);
      check_eq("t6_value", o_value, 45);
      check_eq("t6_count", o_count, 1);
      check_eq("t6_seq_err", o_seq_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
